branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor and resolution unit for the branch_predict pipeline. Holds a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry. It predicts direction and target for the fetch PC and consumes the EX-stage ALU `branch` result to train the table. It also detects mispredicts and issues a registered redirect to fetch, and keeps saturating performance counters.

## Interface
Parameters:
- `IDX_BITS`, 6: BTB index width; 2**IDX_BITS entries, indexed by `pc[IDX_BITS+1:2]`.
- `XLEN`, 32: PC/target width.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `if_pc` in XLEN: fetch-stage PC.
- `pred_taken` out 1: predicted taken for `if_pc`.
- `pred_target` out XLEN: predicted next PC for `if_pc`.
- `ex_valid` in 1: EX stage holds a real instruction.
- `ex_is_branch` in 1: EX instruction is a conditional branch (alu_op[3:2]==2'b11).
- `ex_taken` in 1: ALU `branch` output.
- `ex_pc` in XLEN: PC of the EX instruction.
- `ex_target` in XLEN: computed branch target.
- `ex_pred_taken` in 1: prediction carried down the pipe with this instruction.
- `ex_pred_target` in XLEN: predicted target carried down the pipe.
- `mispredict` out 1: registered flush/redirect request.
- `redirect_pc` out XLEN: registered correct next PC.
- `branch_count` out 32: resolved branches, saturating.
- `mispredict_count` out 32: mispredicts, saturating.

## Operation
- Entry contents: `valid`, `tag` (= `pc[XLEN-1:IDX_BITS+2]`), `target`, `ctr[1:0]`.
- Lookup is combinational. A hit means `valid` && tag match.
  - `pred_taken` = hit && `ctr[1]`.
  - `pred_target` = `pred_taken` ? entry `target` : `if_pc`+4, mod 2**XLEN.
- Update happens when `ex_valid && ex_is_branch`, indexing with `ex_pc`.
  - Hit: `ctr` increments if taken and decrements if not, saturating at 2'b11 and 2'b00. If taken, `target` ← `ex_target`.
  - Miss and taken: allocate the entry (overwrite). Set `valid`=1, the new tag, `target` ← `ex_target`, `ctr`=2'b10.
  - Miss and not taken: no write.
- Alias cleanup: when `ex_valid && !ex_is_branch && ex_pred_taken`, clear `valid` of the matching entry (only if its tag matches).
- Mispredict condition, evaluated in EX:
  - Branch case: `ex_valid && ex_is_branch` && (`ex_taken != ex_pred_taken` || (`ex_taken && ex_target != ex_pred_target`)).
  - Alias case: `ex_valid && !ex_is_branch && ex_pred_taken`.
- Correct PC: `ex_is_branch && ex_taken` ? `ex_target` : `ex_pc`+4.
- Counters: `branch_count` increments on each resolved branch. `mispredict_count` increments on each mispredict. Both hold at 32'hFFFF_FFFF.

## Timing
- Prediction has zero latency: outputs follow `if_pc` and the current table contents in the same cycle.
- Table writes take effect at the rising edge. A same-cycle lookup of the entry being written returns the pre-write contents (no bypass).
- `mispredict`/`redirect_pc` are registered and assert the cycle after the EX event, for exactly one cycle per event. Back-to-back events produce back-to-back pulses.
- Counters update at the same edge as the table.
- Reset (asynchronous, any time, including mid-update):
  - All `valid`=0, `ctr`=2'b01, `tag`/`target`=0.
  - `mispredict`=0, `redirect_pc`=0, both counters 0.
  - An update or pulse pending at reset is discarded.
- During reset, `pred_taken`=0 and `pred_target`=`if_pc`+4.

## Structure
- Package `bp_pkg`:
  - `btb_entry_t` struct.
  - Counter constants `CTR_SNT`=2'b00, `CTR_WNT`=2'b01, `CTR_WT`=2'b10, `CTR_ST`=2'b11.
  - A `sat_inc32` function.
- Sub-module `bp_sat_ctr`: the 2-bit saturating update (inputs ctr and taken, output next ctr), combinational, instantiated once in the update path.
- The table is a flop array (async read required); no SRAM macro.

## Test plan
- Reset, then `if_pc`=0x100 → `pred_taken`=0, `pred_target`=0x104. All counters 0 and `mispredict`=0.
- Taken branch at 0x100 to 0x200 with pred=0 → next cycle `mispredict`=1, `redirect_pc`=0x200. Then `if_pc`=0x100 → `pred_taken`=1, `pred_target`=0x200, ctr=2'b10.
- Three not-taken resolutions of 0x100 starting from ctr=2'b11 → ctr 10, 01, 00 and stays 00 on a fourth. Each not-taken resolved with pred=1 pulses `mispredict` with `redirect_pc`=0x104.
- Alias: 0x1100 shares the index of 0x100 (IDX_BITS=6). Resolve taken 0x1100→0x300 → entry retagged; lookup 0x100 misses. A non-branch at 0x1100 with `ex_pred_taken`=1 → `redirect_pc`=0x1104 and the entry is invalidated.
- Same-cycle lookup and update on 0x100 → lookup returns old contents; the new value is visible the next cycle.
- Force `mispredict_count` near saturation (0xFFFF_FFFE), then apply 3 mispredicts → it holds at 0xFFFF_FFFF. Assert `rst_n` low mid-pulse → `mispredict` and the counters clear immediately.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: BTB entry layout, 2-bit counter states, saturating add.
// No timing of its own; no flow control.
package bp_pkg;

    localparam int BP_XLEN     = 32;
    localparam int BP_IDX_BITS = 6;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Tag is stored zero-extended so the entry layout does not depend on IDX_BITS.
    typedef struct packed {
        logic               valid;
        logic [BP_XLEN-1:0] tag;
        logic [BP_XLEN-1:0] target;
        logic [1:0]         ctr;
    } btb_entry_t;

    localparam btb_entry_t BTB_RST = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// 2-bit saturating direction counter update.
// Combinational, zero latency; no flow control.
module bp_sat_ctr
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB predictor with EX-stage training, mispredict redirect and saturating perf counters.
// Prediction is combinational; redirect/counters register one cycle after EX; no backpressure, one update per cycle.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_BITS = BP_IDX_BITS,
    parameter int XLEN     = BP_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = XLEN - IDX_BITS - 2;

    btb_entry_t btb [ENTRIES];

    logic [IDX_BITS-1:0] if_idx;
    logic [TAG_W-1:0]    if_tag;
    btb_entry_t          if_ent;
    logic                if_hit;

    assign if_idx = if_pc[IDX_BITS+1:2];
    assign if_tag = if_pc[XLEN-1:IDX_BITS+2];
    assign if_ent = btb[if_idx];
    assign if_hit = if_ent.valid && (if_ent.tag == BP_XLEN'(if_tag));

    assign pred_taken  = if_hit && if_ent.ctr[1];
    assign pred_target = pred_taken ? XLEN'(if_ent.target) : if_pc + XLEN'(4);

    logic [IDX_BITS-1:0] ex_idx;
    logic [TAG_W-1:0]    ex_tag;
    btb_entry_t          ex_ent;
    logic                ex_hit;
    logic                br_res;
    logic                alias_res;
    logic                mp;
    logic [XLEN-1:0]     correct_pc;
    logic [1:0]          ctr_next;
    logic                wr_en;
    btb_entry_t          wr_ent;

    assign ex_idx    = ex_pc[IDX_BITS+1:2];
    assign ex_tag    = ex_pc[XLEN-1:IDX_BITS+2];
    assign ex_ent    = btb[ex_idx];
    assign ex_hit    = ex_ent.valid && (ex_ent.tag == BP_XLEN'(ex_tag));
    assign br_res    = ex_valid && ex_is_branch;
    // A non-branch that fetch steered as taken means a stale alias: flush and drop the entry.
    assign alias_res = ex_valid && !ex_is_branch && ex_pred_taken;

    assign mp = (br_res && ((ex_taken != ex_pred_taken) ||
                            (ex_taken && (ex_target != ex_pred_target)))) || alias_res;
    assign correct_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc + XLEN'(4);

    bp_sat_ctr u_sat_ctr (
        .ctr      (ex_ent.ctr),
        .taken    (ex_taken),
        .ctr_next (ctr_next)
    );

    always_comb begin
        wr_en  = 1'b0;
        wr_ent = ex_ent;
        if (br_res) begin
            if (ex_hit) begin
                wr_en      = 1'b1;
                wr_ent.ctr = ctr_next;
                if (ex_taken) wr_ent.target = BP_XLEN'(ex_target);
            end else if (ex_taken) begin
                wr_en         = 1'b1;
                wr_ent.valid  = 1'b1;
                wr_ent.tag    = BP_XLEN'(ex_tag);
                wr_ent.target = BP_XLEN'(ex_target);
                wr_ent.ctr    = CTR_WT;
            end
        end else if (alias_res && ex_hit) begin
            wr_en        = 1'b1;
            wr_ent.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) btb[i] <= BTB_RST;
            mispredict       <= 1'b0;
            redirect_pc      <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (wr_en) btb[ex_idx] <= wr_ent;
            mispredict <= mp;
            if (mp) redirect_pc <= correct_pc;
            if (br_res) branch_count <= sat_inc32(branch_count);
            if (mp) mispredict_count <= sat_inc32(mispredict_count);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: redirect pulses checked by a cycle-stamped scoreboard monitor,
// predictions, table state and counters checked inline against hand-computed values.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc = 32'h100;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid = 1'b0;
    logic        ex_is_branch = 1'b0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_pc = '0;
    logic [31:0] ex_target = '0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = '0;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    branch_predictor dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_is_branch     (ex_is_branch),
        .ex_taken         (ex_taken),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_bc = '0;
    logic [31:0] exp_mc = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a pulse must appear exactly in the cycle the scoreboard stamped, and nowhere else.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("mispredict_pulse", {31'd0, mispredict}, 32'd1);
                chk("redirect_pc", redirect_pc, e.pc);
            end else begin
                chk("no_spurious_mispredict", {31'd0, mispredict}, 32'd0);
            end
        end
    end

    task automatic drive_ex(input logic br, input logic tk, input logic [31:0] pc,
                            input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                            input logic exp_mp, input logic [31:0] exp_rpc, input logic use_sb);
        exp_t e;
        ex_valid       = 1'b1;
        ex_is_branch   = br;
        ex_taken       = tk;
        ex_pc          = pc;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
        if (br && exp_bc != 32'hFFFF_FFFF) exp_bc = exp_bc + 1;
        if (exp_mp && exp_mc != 32'hFFFF_FFFF) exp_mc = exp_mc + 1;
        if (exp_mp && use_sb) begin
            e.cyc = cyc + 1;
            e.pc  = exp_rpc;
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
    endtask

    task automatic issue(input logic br, input logic tk, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                         input logic exp_mp, input logic [31:0] exp_rpc);
        drive_ex(br, tk, pc, tgt, ptk, ptgt, exp_mp, exp_rpc, 1'b1);
        tick();
    endtask

    task automatic chk_pred(input string name, input logic [31:0] pc,
                            input logic exp_tk, input logic [31:0] exp_tgt);
        if_pc = pc;
        #1;
        chk({name, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
        chk({name, "_target"}, pred_target, exp_tgt);
    endtask

    task automatic chk_ctr(input string name, input logic [1:0] exp);
        chk(name, {30'd0, dut.btb[0].ctr}, {30'd0, exp});
    endtask

    task automatic chk_counts(input string name);
        chk({name, "_branch_count"}, branch_count, exp_bc);
        chk({name, "_mispredict_count"}, mispredict_count, exp_mc);
    endtask

    initial begin
        // Reset behaviour
        #1;
        chk_pred("in_reset", 32'h100, 1'b0, 32'h104);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_pred("post_reset", 32'h100, 1'b0, 32'h104);
        chk_counts("post_reset");
        chk("post_reset_mispredict", {31'd0, mispredict}, 32'd0);

        // Allocate on taken miss, then strengthen to strongly taken
        issue(1, 1, 32'h100, 32'h200, 0, 32'h104, 1, 32'h200);
        chk_pred("alloc", 32'h100, 1'b1, 32'h200);
        chk_ctr("alloc_ctr", 2'b10);
        issue(1, 1, 32'h100, 32'h200, 1, 32'h200, 0, 32'h0);
        chk_ctr("strong_ctr", 2'b11);
        chk_counts("strong");

        // Not-taken walk down to saturation
        issue(1, 0, 32'h100, 32'h200, 1, 32'h200, 1, 32'h104);
        chk_ctr("nt1_ctr", 2'b10);
        issue(1, 0, 32'h100, 32'h200, 1, 32'h200, 1, 32'h104);
        chk_ctr("nt2_ctr", 2'b01);
        chk_pred("weak_nt", 32'h100, 1'b0, 32'h104);
        issue(1, 0, 32'h100, 32'h200, 1, 32'h200, 1, 32'h104);
        chk_ctr("nt3_ctr", 2'b00);
        issue(1, 0, 32'h100, 32'h200, 1, 32'h200, 1, 32'h104);
        chk_ctr("nt4_ctr", 2'b00);
        chk_counts("nt_walk");

        // Taken with wrong predicted target, then retrain
        issue(1, 1, 32'h100, 32'h240, 1, 32'h200, 1, 32'h240);
        chk_ctr("tgt_ctr", 2'b01);
        issue(1, 1, 32'h100, 32'h240, 1, 32'h240, 0, 32'h0);
        chk_pred("retarget", 32'h100, 1'b1, 32'h240);
        chk_counts("retarget");

        // Alias retag and cleanup
        issue(1, 1, 32'h1100, 32'h300, 0, 32'h1104, 1, 32'h300);
        chk_pred("alias_old", 32'h100, 1'b0, 32'h104);
        chk_pred("alias_new", 32'h1100, 1'b1, 32'h300);
        issue(0, 0, 32'h1100, 32'h0, 1, 32'h300, 1, 32'h1104);
        chk_pred("alias_clean", 32'h1100, 1'b0, 32'h1104);
        chk("alias_valid", {31'd0, dut.btb[0].valid}, 32'd0);
        chk_counts("alias");

        // Miss and not taken leaves the table alone
        issue(1, 0, 32'h504, 32'h800, 0, 32'h508, 0, 32'h0);
        chk_pred("miss_nt", 32'h504, 1'b0, 32'h508);
        chk("miss_nt_valid", {31'd0, dut.btb[1].valid}, 32'd0);

        // Same-cycle lookup and update: old contents until the edge
        if_pc = 32'h100;
        drive_ex(1, 1, 32'h100, 32'h400, 0, 32'h104, 1, 32'h400, 1);
        #1;
        chk("same_cycle_taken", {31'd0, pred_taken}, 32'd0);
        chk("same_cycle_target", pred_target, 32'h104);
        tick();
        chk_pred("after_write", 32'h100, 1'b1, 32'h400);
        chk_counts("same_cycle");

        // Mispredict counter saturation
        force dut.mispredict_count = 32'hFFFF_FFFE;
        #1;
        release dut.mispredict_count;
        exp_mc = 32'hFFFF_FFFE;
        issue(0, 0, 32'h600, 32'h0, 1, 32'h900, 1, 32'h604);
        issue(0, 0, 32'h600, 32'h0, 1, 32'h900, 1, 32'h604);
        issue(0, 0, 32'h600, 32'h0, 1, 32'h900, 1, 32'h604);
        chk_counts("saturate");

        // Reset in the middle of a pulse
        drive_ex(0, 0, 32'h700, 32'h0, 1, 32'h900, 1, 32'h704, 0);
        tick();
        chk("pre_reset_pulse", {31'd0, mispredict}, 32'd1);
        chk("pre_reset_rpc", redirect_pc, 32'h704);
        rst_n = 1'b0;
        exp_bc = '0;
        exp_mc = '0;
        #1;
        chk("mid_reset_mispredict", {31'd0, mispredict}, 32'd0);
        chk("mid_reset_rpc", redirect_pc, 32'h0);
        chk_counts("mid_reset");
        chk_pred("mid_reset", 32'h100, 1'b0, 32'h104);
        chk_ctr("mid_reset_ctr", 2'b01);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);
        chk_counts("end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
